// File: rtl/dropout_pkg.sv
// Shared types and constants for the dropout scheduling controller.
// Holds the FSM state encoding and the 16-bit LFSR polynomial/seed values.
package dropout_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEED = 2'd1,
    GEN  = 2'd2,
    RUN  = 2'd3
  } state_t;

  // Feedback taps at bits 15, 13, 12 and 10.
  localparam logic [15:0] LFSR_TAPS         = 16'hB400;
  localparam logic [15:0] LFSR_DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] LFSR_RESET_VALUE  = 16'h0001;

  localparam int NEURONS_DEF = 8;
  localparam int DATA_W_DEF  = 8;

  function automatic logic [15:0] lfsrStep(input logic [15:0] s);
    return {s[14:0], ^(s & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/dropout_lfsr16.sv
// 16-bit Fibonacci LFSR that can be loaded with a seed or advanced one step.
// A zero seed would lock the register up, so it is replaced by a fixed default.
module dropout_lfsr16
  import dropout_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_load,
  input  logic        i_advance,
  input  logic [15:0] i_seed,
  output logic [15:0] o_next
);

  logic [15:0] r_lfsr;
  logic [15:0] w_next;

  assign w_next = lfsrStep(r_lfsr);
  assign o_next = w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_lfsr <= LFSR_RESET_VALUE;
    end else if (i_load) begin
      r_lfsr <= (i_seed == 16'h0000) ? LFSR_DEFAULT_SEED : i_seed;
    end else if (i_advance) begin
      r_lfsr <= w_next;
    end
  end

endmodule

// File: rtl/dropout_sched_ctrl.sv
// Dropout controller: builds a keep mask from an LFSR once per batch and
// zeroes dropped neurons in the serial neuron-value stream.
module dropout_sched_ctrl
  import dropout_pkg::*;
#(
  parameter int NEURONS = NEURONS_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LFSR_W  = 16,
  parameter int BATCH_W = 8,
  localparam int IDX_W  = $clog2(NEURONS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic               i_cfg_en,
  input  logic [7:0]         i_cfg_rate,
  input  logic [LFSR_W-1:0]  i_cfg_seed,
  input  logic [BATCH_W-1:0] i_cfg_batch_len,
  input  logic               i_in_valid,
  output logic               o_in_ready,
  input  logic [DATA_W-1:0]  i_in_data,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [DATA_W-1:0]  o_out_data,
  output logic [IDX_W-1:0]   o_out_idx,
  output logic [NEURONS-1:0] o_mask,
  output logic               o_mask_valid,
  output logic               o_busy
);

  state_t r_state;
  state_t w_nextState;

  logic [IDX_W-1:0]   r_genCnt;
  logic [IDX_W-1:0]   r_idx;
  logic [BATCH_W-1:0] r_sampleCnt;
  logic [BATCH_W-1:0] r_batchLen;
  logic [BATCH_W-1:0] w_batchLast;
  logic [NEURONS-1:0] r_mask;
  logic               r_outValid;
  logic [DATA_W-1:0]  r_outData;
  logic [IDX_W-1:0]   r_outIdx;

  logic        w_inReady;
  logic        w_accept;
  logic        w_lastBeat;
  logic        w_batchEnd;
  logic        w_genDone;
  logic [15:0] w_lfsrNext;
  logic        w_unusedLfsrHigh;

  assign w_accept    = i_in_valid && w_inReady;
  assign w_lastBeat  = w_accept && (r_idx == IDX_W'(NEURONS - 1));
  // Length 0 wraps to all-ones, giving 2^BATCH_W samples per mask.
  assign w_batchLast = r_batchLen - BATCH_W'(1);
  assign w_batchEnd  = (r_sampleCnt == w_batchLast);
  assign w_genDone   = (r_genCnt == IDX_W'(NEURONS - 1));

  assign w_unusedLfsrHigh = ^w_lfsrNext[15:8];

  dropout_lfsr16 u_lfsr (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_load    (r_state == SEED),
    .i_advance (r_state == GEN),
    .i_seed    (i_cfg_seed),
    .o_next    (w_lfsrNext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (i_start) w_nextState = SEED;
      SEED: w_nextState = GEN;
      GEN:  if (w_genDone) w_nextState = RUN;
      RUN: begin
        // Stop outranks the batch end; both only act on the last beat of a sample.
        if (w_lastBeat) begin
          if (i_stop)          w_nextState = IDLE;
          else if (w_batchEnd) w_nextState = GEN;
        end
      end
      default: w_nextState = IDLE;
    endcase
  end

  always_comb begin
    w_inReady    = (r_state == RUN) && (!r_outValid || i_out_ready);
    o_mask_valid = (r_state == RUN);
    o_busy       = (r_state != IDLE);
  end

  assign o_in_ready  = w_inReady;
  assign o_out_valid = r_outValid;
  assign o_out_data  = r_outData;
  assign o_out_idx   = r_outIdx;
  assign o_mask      = r_mask;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_genCnt   <= '0;
      r_batchLen <= '0;
      r_mask     <= '1;
    end else begin
      r_genCnt <= (r_state == GEN) ? r_genCnt + IDX_W'(1) : '0;
      if (r_state == SEED || r_state == GEN) r_batchLen <= i_cfg_batch_len;
      if (r_state == GEN)
        r_mask[r_genCnt] <= ~(i_cfg_en & (w_lfsrNext[7:0] < i_cfg_rate));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx       <= '0;
      r_sampleCnt <= '0;
    end else if (w_accept) begin
      r_idx <= r_idx + IDX_W'(1);
      if (w_lastBeat) begin
        r_sampleCnt <= (i_stop || w_batchEnd) ? '0 : r_sampleCnt + BATCH_W'(1);
      end
    end
  end

  // Output register holds its beat under backpressure.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_outValid <= 1'b0;
      r_outData  <= '0;
      r_outIdx   <= '0;
    end else if (w_accept) begin
      r_outValid <= 1'b1;
      r_outData  <= r_mask[r_idx] ? i_in_data : '0;
      r_outIdx   <= r_idx;
    end else if (i_out_ready) begin
      r_outValid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dropout_sched_ctrl.sv
// Scoreboard bench for dropout_sched_ctrl: the driver queues expected beats,
// a negedge monitor pops and compares them as the DUT hands them out.
module tb_dropout_sched_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_start = 1'b0;
  logic       i_stop = 1'b0;
  logic       i_cfg_en = 1'b0;
  logic [7:0] i_cfg_rate = 8'h00;
  logic [15:0] i_cfg_seed = 16'h0000;
  logic [7:0] i_cfg_batch_len = 8'h00;
  logic       i_in_valid = 1'b0;
  logic       o_in_ready;
  logic [7:0] i_in_data = 8'h00;
  logic       o_out_valid;
  logic       i_out_ready = 1'b1;
  logic [7:0] o_out_data;
  logic [2:0] o_out_idx;
  logic [7:0] o_mask;
  logic       o_mask_valid;
  logic       o_busy;

  always #5 clk = ~clk;

  dropout_sched_ctrl dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .i_start         (i_start),
    .i_stop          (i_stop),
    .i_cfg_en        (i_cfg_en),
    .i_cfg_rate      (i_cfg_rate),
    .i_cfg_seed      (i_cfg_seed),
    .i_cfg_batch_len (i_cfg_batch_len),
    .i_in_valid      (i_in_valid),
    .o_in_ready      (o_in_ready),
    .i_in_data       (i_in_data),
    .o_out_valid     (o_out_valid),
    .i_out_ready     (i_out_ready),
    .o_out_data      (o_out_data),
    .o_out_idx       (o_out_idx),
    .o_mask          (o_mask),
    .o_mask_valid    (o_mask_valid),
    .o_busy          (o_busy)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] idx;
  } beat_t;

  beat_t       sb[$];
  int          nCompared = 0;
  int          nMismatched = 0;
  int          cycle = 0;
  logic [15:0] modelLfsr = 16'h0001;
  logic [7:0]  modelMask = 8'hFF;
  logic [2:0]  modelIdx = 3'd0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic logic [15:0] modelStep(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  task automatic modelGen(input logic en, input logic [7:0] rate);
    for (int i = 0; i < 8; i++) begin
      modelLfsr    = modelStep(modelLfsr);
      modelMask[i] = !(en && (modelLfsr[7:0] < rate));
    end
  endtask

  // Monitor: every beat the DUT hands out must match the oldest queued beat.
  always @(negedge clk) begin
    if (rst_n && o_out_valid && i_out_ready) begin
      if (sb.size() == 0) begin
        nCompared++;
        nMismatched++;
        $display("[TB] FAIL unexpected_beat: got data 0x%0h idx %0d, expected no beat",
                 o_out_data, o_out_idx);
      end else begin
        beat_t exp;
        exp = sb.pop_front();
        checkOutput("out_data", 32'(o_out_data), 32'(exp.data));
        checkOutput("out_idx", 32'(o_out_idx), 32'(exp.idx));
      end
    end
  end

  // Waits for RUN, counting SEED/GEN cycles and checking in_ready is held low.
  task automatic waitRun(output int genCycles);
    bit reached;
    genCycles = 0;
    reached   = 1'b0;
    for (int t = 0; t < 100 && !reached; t++) begin
      @(negedge clk);
      if (o_mask_valid) reached = 1'b1;
      else if (o_busy) begin
        genCycles++;
        checkOutput("in_ready_in_gen", 32'(o_in_ready), 32'd0);
      end
    end
    if (!reached) begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL wait_run_timeout: mask_valid got 0, expected 1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic en, input logic [7:0] rate,
                               input logic [15:0] seed, input logic [7:0] batchLen,
                               input logic stopLevel);
    int genCycles;
    i_cfg_en        = en;
    i_cfg_rate      = rate;
    i_cfg_seed      = seed;
    i_cfg_batch_len = batchLen;
    i_stop          = stopLevel;
    i_start         = 1'b1;
    @(posedge clk);
    #1;
    i_start   = 1'b0;
    modelLfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
    waitRun(genCycles);
    checkOutput("seed_gen_cycles", 32'(genCycles), 32'd9);
    modelGen(en, rate);
    checkOutput("mask", 32'(o_mask), 32'(modelMask));
  endtask

  task automatic sendBeat(input logic [7:0] data);
    bit    accepted;
    logic  rdy;
    beat_t exp;
    i_in_valid = 1'b1;
    i_in_data  = data;
    accepted   = 1'b0;
    for (int t = 0; t < 64 && !accepted; t++) begin
      @(negedge clk);
      rdy = o_in_ready;
      @(posedge clk);
      if (rdy) accepted = 1'b1;
    end
    if (accepted) begin
      exp.data = modelMask[modelIdx] ? data : 8'h00;
      exp.idx  = modelIdx;
      sb.push_back(exp);
      modelIdx = modelIdx + 3'd1;
    end else begin
      nCompared++;
      nMismatched++;
      $display("[TB] FAIL beat_timeout: data 0x%0h not accepted, expected accept", data);
    end
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic drainCheck(input string name);
    repeat (3) @(posedge clk);
    #1;
    checkOutput(name, 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int c0;
    int genCycles;
    beat_t held;

    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", 32'(o_out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(o_out_data), 32'd0);
    checkOutput("rst_out_idx", 32'(o_out_idx), 32'd0);
    checkOutput("rst_in_ready", 32'(o_in_ready), 32'd0);
    checkOutput("rst_mask", 32'(o_mask), 32'hFF);
    checkOutput("rst_mask_valid", 32'(o_mask_valid), 32'd0);
    checkOutput("rst_busy", 32'(o_busy), 32'd0);
    @(posedge clk);
    #1;

    $display("[TB] Test 1: bypass");
    applyStimulus(1'b0, 8'hFF, 16'h1234, 8'd0, 1'b0);
    checkOutput("mask_bypass", 32'(o_mask), 32'hFF);
    c0 = cycle;
    for (int i = 0; i < 16; i++) begin
      if (i == 15) i_stop = 1'b1;
      sendBeat(8'(i + 1));
    end
    i_stop = 1'b0;
    checkOutput("bypass_cycles", 32'(cycle - c0), 32'd16);
    checkOutput("bypass_busy_after_stop", 32'(o_busy), 32'd0);
    drainCheck("bypass_sb_empty");

    $display("[TB] Test 2: rate zero");
    applyStimulus(1'b1, 8'h00, 16'h1234, 8'd0, 1'b0);
    checkOutput("mask_rate0", 32'(o_mask), 32'hFF);
    for (int i = 0; i < 8; i++) begin
      if (i == 7) i_stop = 1'b1;
      sendBeat(8'h10 + 8'(i));
    end
    i_stop = 1'b0;
    drainCheck("rate0_sb_empty");

    $display("[TB] Test 3: reference model, batch of two");
    applyStimulus(1'b1, 8'h80, 16'h1234, 8'd2, 1'b0);
    checkOutput("mask_hand_1234", 32'(o_mask), 32'h96);
    for (int i = 0; i < 16; i++) sendBeat(8'hA0 + 8'(i));
    waitRun(genCycles);
    checkOutput("regen_cycles", 32'(genCycles), 32'd8);
    modelGen(1'b1, 8'h80);
    checkOutput("mask_regen", 32'(o_mask), 32'(modelMask));
    for (int i = 0; i < 8; i++) begin
      if (i == 7) i_stop = 1'b1;
      sendBeat(8'hC0 + 8'(i));
    end
    i_stop = 1'b0;
    drainCheck("model_sb_empty");

    $display("[TB] Test 4: backpressure");
    applyStimulus(1'b1, 8'h40, 16'hBEEF, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) sendBeat(8'h31 + 8'(i));
    i_out_ready = 1'b0;
    i_in_valid  = 1'b1;
    i_in_data   = 8'h55;
    held = sb[0];
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("bp_out_valid", 32'(o_out_valid), 32'd1);
      checkOutput("bp_out_data", 32'(o_out_data), 32'(held.data));
      checkOutput("bp_out_idx", 32'(o_out_idx), 32'(held.idx));
      checkOutput("bp_in_ready", 32'(o_in_ready), 32'd0);
      @(posedge clk);
    end
    #1;
    i_out_ready = 1'b1;
    sendBeat(8'h55);
    for (int i = 0; i < 4; i++) begin
      if (i == 3) i_stop = 1'b1;
      sendBeat(8'h60 + 8'(i));
    end
    i_stop = 1'b0;
    drainCheck("bp_sb_empty");

    $display("[TB] Test 5: stop mid-sample");
    applyStimulus(1'b1, 8'h80, 16'h0F0F, 8'd0, 1'b0);
    for (int i = 0; i < 3; i++) sendBeat(8'h70 + 8'(i));
    i_stop = 1'b1;
    for (int i = 3; i < 8; i++) begin
      sendBeat(8'h70 + 8'(i));
      if (i < 7) checkOutput("stop_still_run", 32'(o_mask_valid), 32'd1);
    end
    i_stop = 1'b0;
    checkOutput("stop_busy", 32'(o_busy), 32'd0);
    checkOutput("stop_mask_valid", 32'(o_mask_valid), 32'd0);
    drainCheck("stop_sb_empty");

    $display("[TB] Test 6: async reset and zero seed");
    applyStimulus(1'b1, 8'h80, 16'h2222, 8'd0, 1'b0);
    i_out_ready = 1'b0;
    sendBeat(8'h77);
    checkOutput("pre_reset_out_valid", 32'(o_out_valid), 32'd1);
    #2 rst_n = 1'b0;
    @(negedge clk);
    checkOutput("arst_out_valid", 32'(o_out_valid), 32'd0);
    checkOutput("arst_out_data", 32'(o_out_data), 32'd0);
    checkOutput("arst_out_idx", 32'(o_out_idx), 32'd0);
    checkOutput("arst_in_ready", 32'(o_in_ready), 32'd0);
    checkOutput("arst_mask", 32'(o_mask), 32'hFF);
    checkOutput("arst_mask_valid", 32'(o_mask_valid), 32'd0);
    checkOutput("arst_busy", 32'(o_busy), 32'd0);
    sb.delete();
    modelIdx = 3'd0;
    #2 rst_n = 1'b1;
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 8'h80, 16'h0000, 8'd0, 1'b1);
    for (int i = 0; i < 8; i++) sendBeat(8'hE0 + 8'(i));
    i_stop = 1'b0;
    checkOutput("seed0_busy_after_stop", 32'(o_busy), 32'd0);
    drainCheck("seed0_sb_empty");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
